fp_addsub_arbiter: RTL

//   Shares one combinational Addition_Subtraction unit (IEEE-754 single precision) among
//   NUM_REQ requesters. Round-robin arbitration, operand capture, registered result with

---
 rtl/fp_addsub_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one single-precision add/sub unit among NUM_REQ clients.
// Operands are captured at grant; the result is registered and held under valid/ready.
module fp_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  a_bus,
  input  logic [32*NUM_REQ-1:0]  b_bus,
  input  logic [NUM_REQ-1:0]     sub_bus,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [31:0]            result,
  output logic                   exception
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_sub;
  logic [31:0]       r_result;
  logic              r_exception;
  logic [ID_W-1:0]   r_res_id;
  logic              r_res_valid;

  logic [31:0]       w_a_arr [NUM_REQ];
  logic [31:0]       w_b_arr [NUM_REQ];
  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W:0]     w_idx;
  logic [ID_W-1:0]   w_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_a_arr[gi] = a_bus[32*gi +: 32];
      assign w_b_arr[gi] = b_bus[32*gi +: 32];
    end
  endgenerate

  // First requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      if (!w_found && req[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_ptr_next = (r_id == ID_W'(NUM_REQ-1)) ? '0 : r_id + 1'b1;

  // Grant is gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    w_state_next = r_state;
    gnt          = '0;
    case (r_state)
      IDLE: if (w_found && !reset) begin
        gnt          = NUM_REQ'(1) << w_winner;
        w_state_next = EXEC;
      end
      EXEC: w_state_next = DONE;
      DONE: if (res_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Shared add/sub datapath on the captured operands (truncating).
  logic               w_b_sign_eff;
  logic               w_swap;
  logic [31:0]        w_big;
  logic [31:0]        w_small;
  logic [7:0]         w_diff;
  logic [48:0]        w_ext_big;
  logic [48:0]        w_ext_small;
  logic [48:0]        w_sum;
  logic [5:0]         w_msb;
  logic signed [9:0]  w_exp_r;
  logic [22:0]        w_mant;
  logic [31:0]        w_fp_result;
  logic               w_fp_exc;

  assign w_b_sign_eff = r_b[31] ^ r_sub;
  assign w_swap       = r_b[30:0] > r_a[30:0];
  assign w_big        = w_swap ? {w_b_sign_eff, r_b[30:0]} : r_a;
  assign w_small      = w_swap ? r_a : {w_b_sign_eff, r_b[30:0]};
  assign w_diff       = w_big[30:23] - w_small[30:23];
  assign w_ext_big    = {1'b0, |w_big[30:23], w_big[22:0], 24'b0};
  assign w_ext_small  = {1'b0, |w_small[30:23], w_small[22:0], 24'b0} >> w_diff;
  assign w_sum        = (w_big[31] ^ w_small[31]) ? w_ext_big - w_ext_small
                                                  : w_ext_big + w_ext_small;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 49; i++) if (w_sum[i]) w_msb = 6'(i);
  end

  assign w_exp_r = $signed({2'b00, w_big[30:23]}) + $signed({4'b0000, w_msb}) - 10'sd47;
  assign w_mant  = 23'((w_sum << (6'd48 - w_msb)) >> 25);
  assign w_fp_exc = (&r_a[30:23]) | (&r_b[30:23]);

  always_comb begin
    if (w_sum == '0)               w_fp_result = 32'h0000_0000;
    else if (w_exp_r <= 10'sd0)    w_fp_result = {w_big[31], 31'b0};
    else if (w_exp_r >= 10'sd255)  w_fp_result = {w_big[31], 8'hFF, 23'b0};
    else                           w_fp_result = {w_big[31], w_exp_r[7:0], w_mant};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_res_id    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_a   <= w_a_arr[w_winner];
          r_b   <= w_b_arr[w_winner];
          r_sub <= sub_bus[w_winner];
          r_id  <= w_winner;
        end
        EXEC: begin
          r_result    <= w_fp_result;
          r_exception <= w_fp_exc;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
        end
        DONE: if (res_ready) begin
          r_res_valid <= 1'b0;
          r_rr_ptr    <= w_ptr_next;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign result    = r_result;
  assign exception = r_exception;

endmodule
